dma_bus_arbiter: RTL and testbench

Shares the 6502C system bus (AB/DB/RW) between the CPU and NUM_REQ DMA requesters such as display-list and playfield fetch engines. The block stalls the CPU through its RDY input, waits until the CPU is actually halted, then grants the bus to one requester at a time using round-robin arbitration with a burst limit. It sits between the CPU top level and the memory/bus multiplexer, which it steers through bus_sel.

---
 rtl/dma_bus_arbiter_if.sv | 32 +++
 rtl/dma_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_if.sv
// Bus-sharing handshake between the 6502C, the DMA requesters and the arbiter.
// The arbiter takes the master side; CPU pins and requesters sit on the slave side.
interface dma_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               cpu_RW;
  logic [NUM_REQ-1:0] dma_req;
  logic               RDY;
  logic               bus_sel;
  logic [NUM_REQ-1:0] dma_gnt;
  logic [ID_W-1:0]    gnt_id;

  modport master (
    input  cpu_RW,
    input  dma_req,
    output RDY,
    output bus_sel,
    output dma_gnt,
    output gnt_id
  );

  modport slave (
    output cpu_RW,
    output dma_req,
    input  RDY,
    input  bus_sel,
    input  dma_gnt,
    input  gnt_id
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Halts the 6502C via RDY and hands the system bus to DMA requesters,
// round-robin, with a per-grant burst limit and a guaranteed CPU window.
//
// state     | meaning
// ----------+---------------------------------------------------------
// CPU_OWN   | CPU owns the bus, RDY=1
// HALT_PEND | RDY=0, waiting for a read cycle so the CPU actually stops
// DMA_OWN   | one requester owns the bus, burst_cnt counts transfers
// HANDBACK  | single CPU cycle (RDY=1, bus_sel=0) after a grant ends
module dma_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 8
) (
  input logic              phi0_in,
  input logic              RES_L,
  dma_bus_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HALT_PEND = 2'd1,
    DMA_OWN   = 2'd2,
    HANDBACK  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_id, last_id_nxt;
  logic [CNT_W-1:0]   burst_cnt, burst_nxt;
  logic               grant_new;

  logic               rdy_q, rdy_nxt;
  logic               bus_sel_q, bus_sel_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_nxt;

  logic               any_req;
  logic               cur_req;
  logic [ID_W-1:0]    win_id;
  int                 best;

  assign any_req = |bus.dma_req;
  assign cur_req = bus.dma_req[gnt_id_q];

  // Round-robin: smallest rotational distance strictly after last_id wins.
  always_comb begin
    win_id = last_id;
    best   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.dma_req[i] &&
          (((i - int'(last_id) - 1 + 2 * NUM_REQ) % NUM_REQ) < best)) begin
        best   = (i - int'(last_id) - 1 + 2 * NUM_REQ) % NUM_REQ;
        win_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge phi0_in or negedge RES_L) begin
    if (!RES_L) begin
      state     <= CPU_OWN;
      last_id   <= ID_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      rdy_q     <= 1'b1;
      bus_sel_q <= 1'b0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
    end else begin
      state     <= state_nxt;
      last_id   <= last_id_nxt;
      burst_cnt <= burst_nxt;
      rdy_q     <= rdy_nxt;
      bus_sel_q <= bus_sel_nxt;
      gnt_q     <= gnt_nxt;
      gnt_id_q  <= gnt_id_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_id_nxt = last_id;
    burst_nxt   = burst_cnt;
    grant_new   = 1'b0;
    case (state)
      CPU_OWN: begin
        if (any_req) state_nxt = HALT_PEND;
      end
      HALT_PEND: begin
        // Write cycles ignore RDY, so only a read cycle proves the CPU halted.
        if (!any_req) begin
          state_nxt = CPU_OWN;
        end else if (bus.cpu_RW) begin
          state_nxt   = DMA_OWN;
          grant_new   = 1'b1;
          last_id_nxt = win_id;
          burst_nxt   = '0;
        end
      end
      DMA_OWN: begin
        if (!cur_req) begin
          burst_nxt = '0;
          if (any_req) begin
            grant_new   = 1'b1;
            last_id_nxt = win_id;
          end else begin
            state_nxt = HANDBACK;
          end
        end else begin
          burst_nxt = CNT_W'(burst_cnt + 1'b1);
          if (burst_cnt == CNT_W'(MAX_BURST - 1)) state_nxt = HANDBACK;
        end
      end
      HANDBACK: begin
        // The CPU_OWN re-halt test is applied on the exit edge so the CPU
        // window after a burst stays exactly one cycle wide.
        state_nxt = any_req ? HALT_PEND : CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  always_comb begin
    rdy_nxt     = 1'b1;
    bus_sel_nxt = 1'b0;
    gnt_nxt     = '0;
    gnt_id_nxt  = gnt_id_q;
    case (state_nxt)
      HALT_PEND: rdy_nxt = 1'b0;
      DMA_OWN: begin
        rdy_nxt     = 1'b0;
        bus_sel_nxt = 1'b1;
        if (grant_new) begin
          gnt_nxt    = NUM_REQ'(1) << win_id;
          gnt_id_nxt = win_id;
        end else begin
          gnt_nxt = gnt_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.RDY     = rdy_q;
  assign bus.bus_sel = bus_sel_q;
  assign bus.dma_gnt = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed vector table, corner
// sequences and a randomized run against an ownership-level reference model.
module tb_dma_bus_arbiter;
  localparam int N   = 2;
  localparam int MAXB = 8;

  logic phi0_in;
  logic RES_L;

  dma_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  dma_bus_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .phi0_in (phi0_in),
    .RES_L   (RES_L),
    .bus     (bus)
  );

  initial phi0_in = 1'b0;
  always #5 phi0_in = ~phi0_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, not how the RTL encodes it.
  int m_owner;     // -1: no requester owns the bus
  bit m_halting;   // CPU asked to stop, not yet proven halted
  bit m_handback;  // CPU's guaranteed single cycle
  int m_last;
  int m_gid;
  int m_xfers;

  typedef struct {
    logic [N-1:0] req;
    logic         rw;
    logic         rdy;
    logic         bsel;
    logic [N-1:0] gnt;
    logic         gid;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] req);
    for (int d = 1; d <= N; d++) begin
      if (req[(from + d) % N]) return (from + d) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_halting = 0; m_handback = 0;
    m_last = N - 1; m_gid = 0; m_xfers = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic rw);
    int nxt;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        nxt = pick(m_owner, req);
        if (nxt >= 0) begin
          m_owner = nxt; m_last = nxt; m_gid = nxt; m_xfers = 0;
        end else begin
          m_owner = -1; m_handback = 1;
        end
      end else begin
        m_xfers++;
        if (m_xfers == MAXB) begin
          m_owner = -1; m_handback = 1;
        end
      end
    end else if (m_handback) begin
      m_handback = 0;
      m_halting  = (req != 0);
    end else if (m_halting) begin
      if (req == 0) m_halting = 0;
      else if (rw) begin
        nxt = pick(m_last, req);
        m_owner = nxt; m_last = nxt; m_gid = nxt; m_xfers = 0; m_halting = 0;
      end
    end else if (req != 0) begin
      m_halting = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rdy"},     int'(bus.RDY),     (m_halting || m_owner >= 0) ? 0 : 1);
    chk({tag, ".bus_sel"}, int'(bus.bus_sel), (m_owner >= 0) ? 1 : 0);
    chk({tag, ".gnt"},     int'(bus.dma_gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk({tag, ".gnt_id"},  int'(bus.gnt_id),  m_gid);
  endtask

  task automatic step(input logic [N-1:0] req, input logic rw, input string tag);
    bus.dma_req = req;
    bus.cpu_RW  = rw;
    @(posedge phi0_in);
    model_step(req, rw);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge phi0_in);
    bus.dma_req = '0;
    bus.cpu_RW  = 1'b1;
    #2 RES_L = 1'b0;
    @(negedge phi0_in);
    RES_L = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] g[41];
    logic         r[41];
    logic [N-1:0] rreq;
    logic         rrw;
    int p, len, win;

    tbl[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[2]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[3]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[4]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[5]  = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[8]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[9]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[10] = '{2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    tbl[11] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[12] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[13] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[14] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[15] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};

    RES_L = 1'b1;
    bus.dma_req = '0;
    bus.cpu_RW  = 1'b1;
    model_reset();

    // Reset mid-cycle while idle: outputs settle at once and hold.
    #12 RES_L = 1'b0;
    #1;
    chk("reset_async.rdy",     int'(bus.RDY),     1);
    chk("reset_async.bus_sel", int'(bus.bus_sel), 0);
    chk("reset_async.gnt",     int'(bus.dma_gnt), 0);
    chk("reset_async.gnt_id",  int'(bus.gnt_id),  0);
    @(posedge phi0_in); #1;
    chk("reset_held.rdy", int'(bus.RDY),     1);
    chk("reset_held.gnt", int'(bus.dma_gnt), 0);
    @(negedge phi0_in);
    RES_L = 1'b1;
    step(2'b00, 1'b1, "idle");

    // Directed table: single request, drop after 3 transfers, write stall, withdrawal.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.dma_req = tbl[i].req;
      bus.cpu_RW  = tbl[i].rw;
      @(posedge phi0_in); #1;
      chk($sformatf("tbl%0d.rdy", i),     int'(bus.RDY),     int'(tbl[i].rdy));
      chk($sformatf("tbl%0d.bus_sel", i), int'(bus.bus_sel), int'(tbl[i].bsel));
      chk($sformatf("tbl%0d.gnt", i),     int'(bus.dma_gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d.gnt_id", i),  int'(bus.gnt_id),  int'(tbl[i].gid));
    end

    // Burst limit with both requesters held.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(2'b11, 1'b1, $sformatf("burst%0d", i));
      g[i] = bus.dma_gnt;
      r[i] = bus.RDY;
    end
    g[40] = '0; r[40] = 1'b0;
    p = 0;
    while (p < 40 && g[p] != 2'b01) p++;
    chk("burst_first_grant_cycle", p, 1);
    len = 0;
    while (p < 40 && g[p] == 2'b01) begin len++; p++; end
    chk("burst_len_req0", len, MAXB);
    win = 0;
    while (p < 40 && g[p] == 2'b00) begin if (r[p]) win++; p++; end
    chk("cpu_window_1", win, 1);
    chk("burst_second_grant", int'(g[p]), 2);
    len = 0;
    while (p < 40 && g[p] == 2'b10) begin len++; p++; end
    chk("burst_len_req1", len, MAXB);
    win = 0;
    while (p < 40 && g[p] == 2'b00) begin if (r[p]) win++; p++; end
    chk("cpu_window_2", win, 1);
    chk("burst_third_grant", int'(g[p]), 1);

    // Direct handoff: req0 drops after 2 transfers while req1 waits.
    do_reset();
    step(2'b11, 1'b1, "hand_halt");
    step(2'b11, 1'b1, "hand_grant0");
    step(2'b11, 1'b1, "hand_x1");
    step(2'b11, 1'b1, "hand_x2");
    step(2'b10, 1'b1, "hand_dead");
    chk("handoff_gnt", int'(bus.dma_gnt), 2);
    chk("handoff_rdy", int'(bus.RDY), 0);
    step(2'b10, 1'b1, "hand_x3");

    // Abort a grant with reset, then requester 0 wins again.
    do_reset();
    step(2'b10, 1'b1, "abort_halt");
    step(2'b10, 1'b1, "abort_grant1");
    #2 RES_L = 1'b0;
    #1;
    chk("abort.rdy",     int'(bus.RDY),     1);
    chk("abort.bus_sel", int'(bus.bus_sel), 0);
    chk("abort.gnt",     int'(bus.dma_gnt), 0);
    chk("abort.gnt_id",  int'(bus.gnt_id),  0);
    @(negedge phi0_in);
    RES_L = 1'b1;
    model_reset();
    step(2'b11, 1'b1, "abort_rehalt");
    step(2'b11, 1'b1, "abort_regrant");
    chk("abort_rewin", int'(bus.dma_gnt), 1);

    // Randomized traffic against the model.
    do_reset();
    rreq = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rreq = N'($urandom_range(0, (1 << N) - 1));
      rrw = ($urandom_range(0, 9) < 7);
      step(rreq, rrw, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
